// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
//   state_t       - debug run/drain/halt state encoding
//   CNT_WIDTH_DEF - default width of the saturating perf counters
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
// A load in EX whose destination is read by the instruction in ID cannot be
// forwarded in time, so ID must hold for one cycle.
// Ports:
//   valid_id, valid_ex         - stage valids
//   mem_read_ex, rd_ex         - EX instruction is a load / its destination
//   rs1_id, rs2_id             - ID source registers
//   rs1_used_id, rs2_used_id   - ID instruction actually reads rs1 / rs2
//   load_use                   - hazard present this cycle
module hazard_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      valid_id,
  input  logic                      valid_ex,
  input  logic                      mem_read_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
  input  logic                      rs1_used_id,
  input  logic                      rs2_used_id,
  output logic                      load_use
);

  logic src_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign src_match = (rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex));

  assign load_use = valid_id && valid_ex && mem_read_ex &&
                    (rd_ex != '0) && src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
// Produces hold/cancel strobes for the if_id, id_ex and ex_mem registers from
// load-use hazards, multi-cycle EX busy, branch-mispredict flushes and the
// debug halt/drain/resume FSM. Keeps saturating stall and flush counters.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   valid_id/ex/mem             - stage valids
//   rs1_id, rs2_id, rs*_used_id - ID source operands
//   rd_ex, mem_read_ex          - EX destination / load flag
//   ex_busy                     - multi-cycle unit not finished
//   mispredict_ex, target_ex    - branch resolution and correct PC
//   halt_req, resume_req        - debug control (level / pulse)
//   hold_if, cancel_if_id, hold_id, cancel_id_ex, hold_ex - pipeline strobes
//   redirect_valid, redirect_pc - registered one-cycle PC redirect
//   halted                      - core drained and stopped
//   stall_cnt, flush_cnt        - saturating perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_id,
  input  logic                      valid_ex,
  input  logic                      valid_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
  input  logic                      rs1_used_id,
  input  logic                      rs2_used_id,
  input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
  input  logic                      mem_read_ex,
  input  logic                      ex_busy,
  input  logic                      mispredict_ex,
  input  logic [BUS_WIDTH-1:0]      target_ex,
  input  logic                      halt_req,
  input  logic                      resume_req,
  output logic                      hold_if,
  output logic                      cancel_if_id,
  output logic                      hold_id,
  output logic                      cancel_id_ex,
  output logic                      hold_ex,
  output logic                      redirect_valid,
  output logic [BUS_WIDTH-1:0]      redirect_pc,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  state_t state;
  logic   flush_pending;
  logic   load_use;
  logic   flush;
  logic   drain_done;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .valid_id    (valid_id),
    .valid_ex    (valid_ex),
    .mem_read_ex (mem_read_ex),
    .rd_ex       (rd_ex),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .load_use    (load_use)
  );

  // A mispredict while the multi-cycle unit is still busy is not a resolved
  // branch, so it is not acted on.
  assign flush = mispredict_ex && valid_ex && !ex_busy;

  // Flush outranks hazard holds: the held instruction is on the wrong path.
  assign hold_ex      = ex_busy;
  assign hold_id      = (load_use || ex_busy) && !flush;
  assign cancel_id_ex = flush;
  // flush_pending kills the wrong-path fetch in the cycle the redirect is out.
  assign cancel_if_id = flush || flush_pending || (state == DRAIN);
  assign hold_if      = (state != RUN) || hold_id;

  assign drain_done = !valid_id && !valid_ex && !valid_mem && !ex_busy && !flush_pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      halted         <= 1'b0;
      flush_pending  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      // Redirect is a one-cycle strobe; back-to-back flushes re-arm it.
      redirect_valid <= flush;
      flush_pending  <= flush;
      if (flush) begin
        redirect_pc <= target_ex;
        flush_cnt   <= sat_inc(flush_cnt);
      end
      if (hold_id || hold_ex) begin
        stall_cnt <= sat_inc(stall_cnt);
      end

      halted <= 1'b0;
      case (state)
        RUN: begin
          if (halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if (resume_req) begin
            state <= RUN;
          end else if (drain_done) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (resume_req) state <= RUN;
          else            halted <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_id, valid_ex, valid_mem;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        rs1_used_id, rs2_used_id, mem_read_ex;
  logic        ex_busy, mispredict_ex;
  logic [31:0] target_ex;
  logic        halt_req, resume_req;

  logic        hold_if, cancel_if_id, hold_id, cancel_id_ex, hold_ex;
  logic        redirect_valid, halted;
  logic [31:0] redirect_pc;
  logic [15:0] stall_cnt, flush_cnt;

  logic        hold_if4, cancel_if_id4, hold_id4, cancel_id_ex4, hold_ex4;
  logic        redirect_valid4, halted4;
  logic [31:0] redirect_pc4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .ex_busy(ex_busy),
    .mispredict_ex(mispredict_ex), .target_ex(target_ex),
    .halt_req(halt_req), .resume_req(resume_req),
    .hold_if(hold_if), .cancel_if_id(cancel_if_id), .hold_id(hold_id),
    .cancel_id_ex(cancel_id_ex), .hold_ex(hold_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.BUS_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .ex_busy(ex_busy),
    .mispredict_ex(mispredict_ex), .target_ex(target_ex),
    .halt_req(halt_req), .resume_req(resume_req),
    .hold_if(hold_if4), .cancel_if_id(cancel_if_id4), .hold_id(hold_id4),
    .cancel_id_ex(cancel_id_ex4), .hold_ex(hold_ex4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct {
    string      name;
    logic       vid, vex;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, busy, mis;
    logic       e_hold_if, e_cif, e_hold_id, e_cide, e_hold_ex;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_id = 0; valid_ex = 0; valid_mem = 0;
    rs1_id = 0; rs2_id = 0; rd_ex = 0;
    rs1_used_id = 0; rs2_used_id = 0; mem_read_ex = 0;
    ex_busy = 0; mispredict_ex = 0; target_ex = 0;
    halt_req = 0; resume_req = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    next();
    next();
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_stall;
    int exp_flush;
    //                name        vid vex rs1 rs2 u1 u2 rd mr bsy mis | hif cif hid cide hex
    vecs[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[1]  = '{"lu_rs1",      1, 1, 5, 0, 1, 0, 5, 1, 0, 0,   1, 0, 1, 0, 0};
    vecs[2]  = '{"lu_rd0",      1, 1, 0, 0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0};
    vecs[3]  = '{"lu_rs2",      1, 1, 1, 7, 1, 1, 7, 1, 0, 0,   1, 0, 1, 0, 0};
    vecs[4]  = '{"lu_rs2_unused",1,1, 1, 7, 1, 0, 7, 1, 0, 0,   0, 0, 0, 0, 0};
    vecs[5]  = '{"lu_not_load", 1, 1, 5, 0, 1, 0, 5, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[6]  = '{"lu_id_invalid",0,1, 5, 0, 1, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0};
    vecs[7]  = '{"busy",        0, 1, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 1};
    vecs[8]  = '{"mispredict",  0, 1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0};
    vecs[9]  = '{"mis_ex_inval",0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0};
    vecs[10] = '{"mis_and_lu",  1, 1, 3, 0, 1, 0, 3, 1, 0, 1,   0, 1, 0, 1, 0};
    vecs[11] = '{"illegal_mis_busy",0,1,0,0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_hold_if", hold_if, 0);
    chk("rst_cancel_if_id", cancel_if_id, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);

    // Single-cycle combinational vectors, separated by idle cycles
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      valid_id = vecs[i].vid; valid_ex = vecs[i].vex;
      rs1_id = vecs[i].rs1; rs2_id = vecs[i].rs2;
      rs1_used_id = vecs[i].u1; rs2_used_id = vecs[i].u2;
      rd_ex = vecs[i].rd; mem_read_ex = vecs[i].mr;
      ex_busy = vecs[i].busy; mispredict_ex = vecs[i].mis;
      target_ex = 32'h40 + i;
      @(negedge clk);
      chk({vecs[i].name, "_hold_if"}, hold_if, vecs[i].e_hold_if);
      chk({vecs[i].name, "_cancel_if_id"}, cancel_if_id, vecs[i].e_cif);
      chk({vecs[i].name, "_hold_id"}, hold_id, vecs[i].e_hold_id);
      chk({vecs[i].name, "_cancel_id_ex"}, cancel_id_ex, vecs[i].e_cide);
      chk({vecs[i].name, "_hold_ex"}, hold_ex, vecs[i].e_hold_ex);
      if (vecs[i].e_hold_id || vecs[i].e_hold_ex) exp_stall++;
      if (vecs[i].e_cide) exp_flush++;
      next();
      idle();
      next();
      next();
    end
    @(negedge clk);
    chk("tbl_stall_cnt", stall_cnt, exp_stall);
    chk("tbl_flush_cnt", flush_cnt, exp_flush);

    // Mispredict sequence
    do_reset();
    valid_ex = 1; mispredict_ex = 1; target_ex = 32'h0000_0100;
    @(negedge clk);
    chk("mp0_cancel_if_id", cancel_if_id, 1);
    chk("mp0_cancel_id_ex", cancel_id_ex, 1);
    chk("mp0_redirect_valid", redirect_valid, 0);
    next();
    idle();
    @(negedge clk);
    chk("mp1_redirect_valid", redirect_valid, 1);
    chk("mp1_redirect_pc", redirect_pc, 32'h100);
    chk("mp1_cancel_if_id", cancel_if_id, 1);
    chk("mp1_cancel_id_ex", cancel_id_ex, 0);
    next();
    @(negedge clk);
    chk("mp2_redirect_valid", redirect_valid, 0);
    chk("mp2_cancel_if_id", cancel_if_id, 0);
    chk("mp2_flush_cnt", flush_cnt, 1);

    // Back-to-back flushes: latest target wins
    valid_ex = 1; mispredict_ex = 1; target_ex = 32'h200;
    next();
    target_ex = 32'h300;
    @(negedge clk);
    chk("b2b1_redirect_pc", redirect_pc, 32'h200);
    next();
    idle();
    @(negedge clk);
    chk("b2b2_redirect_valid", redirect_valid, 1);
    chk("b2b2_redirect_pc", redirect_pc, 32'h300);
    chk("b2b2_cancel_if_id", cancel_if_id, 1);
    next();
    @(negedge clk);
    chk("b2b3_redirect_valid", redirect_valid, 0);
    chk("b2b3_cancel_if_id", cancel_if_id, 0);
    chk("b2b3_flush_cnt", flush_cnt, 3);

    // ex_busy for exactly 3 cycles
    do_reset();
    valid_ex = 1; ex_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_hold_ex", hold_ex, 1);
      chk("busy_hold_id", hold_id, 1);
      next();
    end
    idle();
    @(negedge clk);
    chk("busy_end_hold_ex", hold_ex, 0);
    chk("busy_end_hold_id", hold_id, 0);
    chk("busy_stall_cnt", stall_cnt, 3);

    // Halt with in-flight instructions, drain, resume
    do_reset();
    valid_id = 1; valid_ex = 1; valid_mem = 1; halt_req = 1;
    @(negedge clk);
    chk("halt_run_hold_if", hold_if, 0);
    chk("halt_run_cancel_if_id", cancel_if_id, 0);
    next();
    halt_req = 0;
    @(negedge clk);
    chk("drain1_cancel_if_id", cancel_if_id, 1);
    chk("drain1_hold_if", hold_if, 1);
    chk("drain1_halted", halted, 0);
    next();
    valid_id = 0;
    @(negedge clk);
    chk("drain2_cancel_if_id", cancel_if_id, 1);
    next();
    valid_ex = 0;
    @(negedge clk);
    chk("drain3_cancel_if_id", cancel_if_id, 1);
    chk("drain3_halted", halted, 0);
    next();
    valid_mem = 0;
    @(negedge clk);
    chk("drain4_cancel_if_id", cancel_if_id, 1);
    chk("drain4_halted", halted, 0);
    next();
    @(negedge clk);
    chk("halted_halted", halted, 1);
    chk("halted_hold_if", hold_if, 1);
    chk("halted_cancel_if_id", cancel_if_id, 0);
    next();
    resume_req = 1; halt_req = 1;
    @(negedge clk);
    chk("resume_cycle_halted", halted, 1);
    next();
    resume_req = 0; halt_req = 0;
    @(negedge clk);
    chk("resumed_halted", halted, 0);
    chk("resumed_hold_if", hold_if, 0);

    // Simultaneous halt and resume in RUN: halt wins; then resume from DRAIN
    halt_req = 1; resume_req = 1;
    next();
    halt_req = 0; resume_req = 0;
    @(negedge clk);
    chk("hr_drain_hold_if", hold_if, 1);
    chk("hr_drain_cancel_if_id", cancel_if_id, 1);
    resume_req = 1;
    next();
    resume_req = 0;
    @(negedge clk);
    chk("drain_resume_hold_if", hold_if, 0);
    chk("drain_resume_cancel_if_id", cancel_if_id, 0);

    // Reset while HALTED
    do_reset();
    ex_busy = 1;
    next();
    ex_busy = 0; halt_req = 1;
    next();
    halt_req = 0;
    next();
    @(negedge clk);
    chk("pre_rst_halted", halted, 1);
    chk("pre_rst_stall_cnt", stall_cnt, 1);
    rst_n = 0;
    next();
    rst_n = 1;
    @(negedge clk);
    chk("rst_halt_halted", halted, 0);
    chk("rst_halt_hold_if", hold_if, 0);
    chk("rst_halt_stall_cnt", stall_cnt, 0);

    // Reset in the flush_pending cycle
    valid_ex = 1; mispredict_ex = 1; target_ex = 32'h80;
    next();
    idle();
    rst_n = 0;
    @(negedge clk);
    chk("pre_rst_redirect_valid", redirect_valid, 1);
    next();
    rst_n = 1;
    @(negedge clk);
    chk("rst_fp_redirect_valid", redirect_valid, 0);
    chk("rst_fp_redirect_pc", redirect_pc, 0);
    chk("rst_fp_cancel_if_id", cancel_if_id, 0);
    chk("rst_fp_flush_cnt", flush_cnt, 0);

    // Saturation under a long ex_busy
    do_reset();
    valid_ex = 1; ex_busy = 1;
    repeat (20) next();
    idle();
    @(negedge clk);
    chk("sat_stall_cnt4", stall_cnt4, 15);
    chk("sat_stall_cnt16", stall_cnt, 20);
    next();
    @(negedge clk);
    chk("sat_hold_stall_cnt4", stall_cnt4, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Generates the per-stage hold/cancel strobes consumed by the if_id, id_ex and ex_mem pipeline registers, which use the valid/ready_go/allow_in handshake. Sources of these strobes:
- load-use hazard detection
- multi-cycle EX busy
- branch-mispredict flush with a registered PC redirect
- a debug halt/drain/resume state machine

Also keeps saturating stall and flush performance counters.

Parameters:
BUS_WIDTH, 32, PC/address width
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 16, width of each perf counter (saturating)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-low
valid_id  in  1  ID stage holds a valid instruction
valid_ex  in  1  EX stage valid
valid_mem  in  1  MEM stage valid
rs1_id  in  REG_ADDR_WIDTH  ID source reg 1
rs2_id  in  REG_ADDR_WIDTH  ID source reg 2
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_ex  in  REG_ADDR_WIDTH  EX destination reg
mem_read_ex  in  1  EX instruction is a load
ex_busy  in  1  multi-cycle unit (mul/div) in EX not finished
mispredict_ex  in  1  branch/jump resolved in EX disagrees with prediction
target_ex  in  BUS_WIDTH  correct next PC for mispredict
halt_req  in  1  debug halt request, level
resume_req  in  1  debug resume request, pulse
hold_if  out  1  freeze PC generator
cancel_if_id  out  1  to if_id cancel
hold_id  out  1  to if_id hold (drops ready_go_id)
cancel_id_ex  out  1  to id_ex cancel
hold_ex  out  1  to id_ex hold
redirect_valid  out  1  one-cycle PC redirect strobe, registered
redirect_pc  out  BUS_WIDTH  redirect target, registered
halted  out  1  core fully drained and stopped
stall_cnt  out  CNT_WIDTH  cycles with hold_id or hold_ex asserted
flush_cnt  out  CNT_WIDTH  number of mispredict flushes

Behaviour:
- Reset (rst_n=0 at posedge): state=RUN, flush_pending=0, redirect_valid=0, redirect_pc=0, counters=0, halted=0. All combinational outputs are then 0 when inputs are idle. Reset mid-DRAIN or mid-HALTED returns to RUN with no redirect.
- load_use = valid_id & valid_ex & mem_read_ex & (rd_ex!=0) & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)). Combinational, same cycle.
- flush = mispredict_ex & valid_ex & !ex_busy.
- hold_ex = ex_busy.
- hold_id = (load_use | ex_busy) & !flush.
- cancel_id_ex = flush.
- cancel_if_id = flush | flush_pending | (state==DRAIN).
- hold_if = (state!=RUN) | hold_id.
- Flush sequencing: on a flush cycle, register redirect_valid=1, redirect_pc=target_ex, flush_pending=1, flush_cnt+=1 (saturating). In the next cycle:
  - redirect_valid is high for exactly 1 cycle;
  - cancel_if_id stays high to kill the wrong-path fetch;
  - flush_pending then clears.
  Back-to-back flushes re-arm flush_pending, and redirect_pc takes the latest target.
- Priority: flush > load_use/ex_busy hold. Both of mispredict_ex and ex_busy high at once is illegal; flush is suppressed and the bench flags it.
- FSM (state held in a register):
  - RUN: halt_req=1 -> DRAIN.
  - DRAIN: fetch frozen, IF->ID entry cancelled, in-flight instructions complete. When !valid_id & !valid_ex & !valid_mem & !ex_busy & !flush_pending -> HALTED. A flush inside DRAIN is still honoured (redirect issued, state stays DRAIN). resume_req in DRAIN -> RUN.
  - HALTED: halted=1, hold_if=1. resume_req -> RUN. halt_req is ignored while resume_req=1.
  - In RUN, simultaneous halt_req and resume_req -> DRAIN (halt wins).
- halted is registered: it is 1 in the cycles the state is HALTED.
- stall_cnt increments each cycle (hold_id|hold_ex)=1 and saturates at all-ones. Likewise flush_cnt saturates.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding localparams (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), CNT_WIDTH default.
- Sub-module hazard_detect: purely combinational load_use computation. Reusable by a future forwarding unit.

Test Plan:
- Load-use: load x5 in EX, ID reads rs1=x5 (rs1_used_id=1) -> hold_id=1, hold_if=1 for 1 cycle; stall_cnt 0->1; no hold if rd_ex=0.
- Mispredict: mispredict_ex=1, target_ex=0x0000_0100 -> same cycle cancel_if_id=cancel_id_ex=1. Next cycle redirect_valid=1, redirect_pc=0x100, cancel_if_id=1. Following cycle all 0; flush_cnt=1.
- Mispredict coincident with load-use -> hold_id=0, cancels asserted, redirect issued.
- ex_busy held 3 cycles -> hold_ex=hold_id=1 for exactly 3 cycles; stall_cnt=3.
- Halt: halt_req=1 with valid_id/ex/mem busy, draining over 3 cycles -> cancel_if_id=1 throughout DRAIN, halted=1 once all valids=0. resume_req pulse -> RUN, hold_if=0 next cycle.
- Reset asserted in HALTED and in the flush_pending cycle -> next cycle state RUN, redirect_valid=0, counters=0; stall_cnt saturates at 0xFFFF under a long ex_busy (CNT_WIDTH=4 run: stops at 15).
